// File: rtl/cnn_drain_pkg.sv
// Shared types and AXI encodings for the layer-1 result drain master.
package cnn_drain_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_AR,
        S_R,
        S_AW,
        S_W,
        S_B
    } drain_state_t;

    localparam logic [3:0] LEN_4BEAT  = 4'd3;
    localparam logic [2:0] SIZE_WORD  = 3'b010;
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [3:0] STRB_ALL   = 4'hF;
    localparam int         BEATS      = 4;
    localparam int         DATA_W     = 32;

    // Each 128-bit vector occupies one 16-byte slot in the destination region.
    function automatic logic [31:0] vec_addr(input logic [31:0] base, input logic [15:0] idx);
        return base + {12'd0, idx, 4'd0};
    endfunction

endpackage

// File: rtl/cnn_beat_buffer.sv
// Four-beat staging buffer between the read burst and the write burst of one vector.
module cnn_beat_buffer
    import cnn_drain_pkg::*;
(
    input  logic              clk,
    input  logic              resetn,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_adv,
    output logic [1:0]        wr_ptr,
    output logic [1:0]        rd_ptr,
    output logic [DATA_W-1:0] rd_data
);

    logic [BEATS-1:0][DATA_W-1:0] mem;

    // Clearing zeroes the data too, so a short read burst leaves zero beats behind.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clr) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + 2'd1;
            end
            if (rd_adv) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
        end
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/cnn_l1_result_drain.sv
// AXI master that copies layer-1 result vectors from the wrapper to a destination region.
`ifndef AXI_ID_BITS
`define AXI_ID_BITS 4
`endif
module cnn_l1_result_drain
    import cnn_drain_pkg::*;
#(
    parameter logic [31:0]             SRC_ADDR  = 32'h3000_0000,
    parameter logic [31:0]             DST_BASE  = 32'h2000_0000,
    parameter int                      VEC_COUNT = 16,
    parameter logic [`AXI_ID_BITS-1:0] MST_ID    = 4'd2
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    cnn_interrupt,

    output logic [`AXI_ID_BITS-1:0] ARID,
    output logic [31:0]             ARADDR,
    output logic [3:0]              ARLEN,
    output logic [2:0]              ARSIZE,
    output logic [1:0]              ARBURST,
    output logic                    ARVALID,
    input  logic                    ARREADY,

    input  logic [`AXI_ID_BITS-1:0] RID,
    input  logic [31:0]             RDATA,
    input  logic [1:0]              RRESP,
    input  logic                    RLAST,
    input  logic                    RVALID,
    output logic                    RREADY,

    output logic [`AXI_ID_BITS-1:0] AWID,
    output logic [31:0]             AWADDR,
    output logic [3:0]              AWLEN,
    output logic [2:0]              AWSIZE,
    output logic [1:0]              AWBURST,
    output logic                    AWVALID,
    input  logic                    AWREADY,

    output logic [31:0]             WDATA,
    output logic [3:0]              WSTRB,
    output logic                    WLAST,
    output logic                    WVALID,
    input  logic                    WREADY,

    input  logic [`AXI_ID_BITS-1:0] BID,
    input  logic [1:0]              BRESP,
    input  logic                    BVALID,
    output logic                    BREADY,

    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic [15:0]             vec_idx
);

    drain_state_t state;
    logic         int_q;
    logic         pending;
    logic         discard;
    logic         int_rise;
    logic         last_vec;

    logic         buf_clr;
    logic         buf_wr;
    logic         buf_rd;
    logic [1:0]   buf_wr_ptr;
    logic [1:0]   buf_rd_ptr;
    logic [31:0]  buf_rd_data;

    assign ARID    = MST_ID;
    assign ARLEN   = LEN_4BEAT;
    assign ARSIZE  = SIZE_WORD;
    assign ARBURST = BURST_INCR;
    assign AWID    = MST_ID;
    assign AWLEN   = LEN_4BEAT;
    assign AWSIZE  = SIZE_WORD;
    assign AWBURST = BURST_INCR;
    assign WSTRB   = STRB_ALL;
    assign WDATA   = buf_rd_data;

    assign int_rise = cnn_interrupt & ~int_q;
    assign last_vec = (vec_idx == 16'(VEC_COUNT - 1));

    // The buffer is wiped as the read address is accepted, before any R beat lands.
    assign buf_clr = (state == S_AR) && ARREADY;
    assign buf_wr  = (state == S_R) && RVALID && !discard;
    assign buf_rd  = (state == S_W) && WREADY;

    cnn_beat_buffer u_buf (
        .clk     (clk),
        .resetn  (resetn),
        .clr     (buf_clr),
        .wr_en   (buf_wr),
        .wr_data (RDATA),
        .rd_adv  (buf_rd),
        .wr_ptr  (buf_wr_ptr),
        .rd_ptr  (buf_rd_ptr),
        .rd_data (buf_rd_data)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= S_IDLE;
            int_q   <= 1'b0;
            pending <= 1'b0;
            discard <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            vec_idx <= '0;
            ARVALID <= 1'b0;
            ARADDR  <= '0;
            RREADY  <= 1'b0;
            AWVALID <= 1'b0;
            AWADDR  <= '0;
            WVALID  <= 1'b0;
            WLAST   <= 1'b0;
            BREADY  <= 1'b0;
        end else begin
            int_q <= cnn_interrupt;
            done  <= 1'b0;
            // Only one request can be remembered while a sequence is running.
            if (int_rise && state != S_IDLE) begin
                pending <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (int_rise || pending) begin
                        pending <= 1'b0;
                        err     <= 1'b0;
                        vec_idx <= '0;
                        busy    <= 1'b1;
                        ARVALID <= 1'b1;
                        ARADDR  <= SRC_ADDR;
                        state   <= S_AR;
                    end
                end

                S_AR: begin
                    if (ARREADY) begin
                        ARVALID <= 1'b0;
                        RREADY  <= 1'b1;
                        discard <= 1'b0;
                        state   <= S_R;
                    end
                end

                S_R: begin
                    if (RVALID) begin
                        if (RRESP != RESP_OKAY || RID != MST_ID) begin
                            err <= 1'b1;
                        end
                        if (RLAST) begin
                            if (!discard && buf_wr_ptr != 2'd3) begin
                                err <= 1'b1;
                            end
                            RREADY  <= 1'b0;
                            AWVALID <= 1'b1;
                            AWADDR  <= vec_addr(DST_BASE, vec_idx);
                            state   <= S_AW;
                        end else if (!discard && buf_wr_ptr == 2'd3) begin
                            // Slave overran the burst: keep accepting until it ends.
                            err     <= 1'b1;
                            discard <= 1'b1;
                        end
                    end
                end

                S_AW: begin
                    if (AWREADY) begin
                        AWVALID <= 1'b0;
                        WVALID  <= 1'b1;
                        WLAST   <= 1'b0;
                        state   <= S_W;
                    end
                end

                S_W: begin
                    if (WREADY) begin
                        if (buf_rd_ptr == 2'd3) begin
                            WVALID <= 1'b0;
                            WLAST  <= 1'b0;
                            BREADY <= 1'b1;
                            state  <= S_B;
                        end else begin
                            WLAST <= (buf_rd_ptr == 2'd2);
                        end
                    end
                end

                S_B: begin
                    if (BVALID) begin
                        if (BRESP != RESP_OKAY || BID != MST_ID) begin
                            err <= 1'b1;
                        end
                        BREADY <= 1'b0;
                        if (last_vec) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end else begin
                            vec_idx <= vec_idx + 16'd1;
                            ARVALID <= 1'b1;
                            ARADDR  <= SRC_ADDR;
                            state   <= S_AR;
                        end
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cnn_l1_result_drain.sv
// Directed bench: behavioural AXI slave around the drain master, expectations hand-computed.
`ifndef AXI_ID_BITS
`define AXI_ID_BITS 4
`endif
module tb_cnn_l1_result_drain;

    localparam logic [31:0] SRC = 32'h3000_0000;
    localparam logic [31:0] DST = 32'h2000_0000;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic cnn_interrupt = 1'b0;

    logic [`AXI_ID_BITS-1:0] ARID, AWID;
    logic [`AXI_ID_BITS-1:0] RID = 4'd2;
    logic [`AXI_ID_BITS-1:0] BID = 4'd2;
    logic [31:0] ARADDR, AWADDR, WDATA;
    logic [31:0] RDATA = '0;
    logic [3:0]  ARLEN, AWLEN, WSTRB;
    logic [2:0]  ARSIZE, AWSIZE;
    logic [1:0]  ARBURST, AWBURST;
    logic [1:0]  RRESP = '0;
    logic [1:0]  BRESP = '0;
    logic ARVALID, AWVALID, WVALID, WLAST, RREADY, BREADY;
    logic ARREADY = 1'b0, AWREADY = 1'b0, WREADY = 1'b0;
    logic RVALID = 1'b0, RLAST = 1'b0, BVALID = 1'b0;
    logic busy, done, err;
    logic [15:0] vec_idx;

    always #5 clk = ~clk;

    cnn_l1_result_drain #(
        .SRC_ADDR(SRC), .DST_BASE(DST), .VEC_COUNT(2), .MST_ID(4'd2)
    ) dut (
        .clk(clk), .resetn(resetn), .cnn_interrupt(cnn_interrupt),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .busy(busy), .done(done), .err(err), .vec_idx(vec_idx)
    );

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        chk(tag, 32'(obs), 32'(exp));
    endtask

    // Slave configuration and state
    bit         stall_en = 0;
    int         r_last0 = 3;
    logic [1:0] bresp0 = 2'b00;
    int ar_wait = 0, aw_wait = 0, w_wait = 0;
    bit r_active = 0, b_pend = 0;
    int r_cnt = 0, rd_vec = 0, wr_vec = 0, w_cnt = 0;
    logic [31:0] aw_q[$];
    logic [31:0] wd_q[$];
    logic        wl_q[$];

    // Slave outputs change on the falling edge only.
    always @(negedge clk) begin
        ARREADY = 1'b0; AWREADY = 1'b0; WREADY = 1'b0;
        RVALID = 1'b0; RLAST = 1'b0; RDATA = '0; RRESP = 2'b00;
        BVALID = 1'b0; BRESP = 2'b00;
        if (resetn) begin
            if (ARVALID) begin if (ar_wait == 0) ARREADY = 1'b1; else ar_wait--; end
            if (AWVALID) begin if (aw_wait == 0) AWREADY = 1'b1; else aw_wait--; end
            if (WVALID)  begin if (w_wait == 0)  WREADY = 1'b1;  else w_wait--;  end
            if (r_active) begin
                RVALID = 1'b1;
                RDATA  = 32'h11 * 32'(4 * rd_vec + r_cnt + 1);
                RLAST  = (r_cnt == ((rd_vec == 0) ? r_last0 : 3));
            end
            if (b_pend) begin
                BVALID = 1'b1;
                BRESP  = (wr_vec == 0) ? bresp0 : 2'b00;
            end
        end
    end

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_active = 0; b_pend = 0; r_cnt = 0; w_cnt = 0;
            rd_vec = 0; wr_vec = 0; ar_wait = 0; aw_wait = 0; w_wait = 0;
        end else begin
            if (RVALID && RREADY) begin
                if (RLAST) begin r_active = 0; rd_vec++; end
                else r_cnt++;
            end
            if (ARVALID && ARREADY) begin
                r_active = 1; r_cnt = 0;
                ar_wait = stall_en ? $urandom_range(0, 5) : 0;
            end
            if (AWVALID && AWREADY) begin
                aw_q.push_back(AWADDR);
                aw_wait = stall_en ? $urandom_range(0, 5) : 0;
            end
            if (BVALID && BREADY) begin b_pend = 0; wr_vec++; end
            if (WVALID && WREADY) begin
                wd_q.push_back(WDATA);
                wl_q.push_back(WLAST);
                w_wait = stall_en ? $urandom_range(0, 5) : 0;
                w_cnt++;
                if (WLAST) begin b_pend = 1; w_cnt = 0; end
            end
        end
    end

    // A VALID seen without READY at an edge must survive that edge with the same payload.
    logic        ar_hold = 0, aw_hold = 0, w_hold = 0;
    logic [31:0] ar_addr_p, aw_addr_p, wd_p;
    logic        wl_p;
    always @(posedge clk) begin
        #1;
        if (!resetn) begin
            ar_hold = 0; aw_hold = 0; w_hold = 0;
        end else begin
            if (ar_hold && !ARREADY) begin
                chk1("ar_valid_held", ARVALID, 1'b1);
                chk("ar_addr_stable", ARADDR, ar_addr_p);
            end
            if (aw_hold && !AWREADY) begin
                chk1("aw_valid_held", AWVALID, 1'b1);
                chk("aw_addr_stable", AWADDR, aw_addr_p);
            end
            if (w_hold && !WREADY) begin
                chk1("w_valid_held", WVALID, 1'b1);
                chk("w_data_stable", WDATA, wd_p);
                chk1("w_last_stable", WLAST, wl_p);
            end
            ar_hold = ARVALID; ar_addr_p = ARADDR;
            aw_hold = AWVALID; aw_addr_p = AWADDR;
            w_hold  = WVALID;  wd_p = WDATA; wl_p = WLAST;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic new_test();
        aw_q.delete(); wd_q.delete(); wl_q.delete();
        rd_vec = 0; wr_vec = 0; ar_wait = 0; aw_wait = 0; w_wait = 0;
    endtask

    task automatic wait_done(input int budget, output int n);
        n = 0;
        while (!done && n < budget) begin tick(); n++; end
        if (!done) chk1("done_timeout", done, 1'b1);
    endtask

    task automatic wait_vec1(input int budget);
        int n = 0;
        while (vec_idx != 16'd1 && n < budget) begin tick(); n++; end
        if (vec_idx != 16'd1) chk("vec1_timeout", 32'(vec_idx), 32'd1);
    endtask

    logic [31:0] exp_a[8] = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55, 32'h66, 32'h77, 32'h88};
    logic [31:0] exp_s[8] = '{32'h11, 32'h22, 32'h0,  32'h0,  32'h55, 32'h66, 32'h77, 32'h88};
    int n;
    int k;

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk1("rst_arvalid", ARVALID, 1'b0);
        chk1("rst_awvalid", AWVALID, 1'b0);
        chk1("rst_wvalid", WVALID, 1'b0);
        chk1("rst_rready", RREADY, 1'b0);
        chk1("rst_bready", BREADY, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk1("rst_err", err, 1'b0);
        chk("rst_vec_idx", 32'(vec_idx), 32'd0);
        resetn = 1'b1;
        tick();

        // Zero-wait, two vectors
        new_test();
        cnn_interrupt = 1'b1;
        tick();
        chk1("start_arvalid", ARVALID, 1'b1);
        chk1("start_busy", busy, 1'b1);
        chk("start_araddr", ARADDR, SRC);
        chk("arlen", 32'(ARLEN), 32'd3);
        chk("arsize", 32'(ARSIZE), 32'd2);
        chk("arburst", 32'(ARBURST), 32'd1);
        chk("arid", 32'(ARID), 32'd2);
        chk("awlen", 32'(AWLEN), 32'd3);
        chk("wstrb", 32'(WSTRB), 32'hF);
        cnn_interrupt = 1'b0;
        wait_done(200, n);
        chk("done_latency", 32'(n + 1), 32'd23);
        chk1("t1_err", err, 1'b0);
        chk1("t1_busy_at_done", busy, 1'b0);
        tick();
        chk1("done_one_pulse", done, 1'b0);
        chk("t1_aw_count", 32'(aw_q.size()), 32'd2);
        chk("t1_aw0", aw_q[0], DST);
        chk("t1_aw1", aw_q[1], DST + 32'h10);
        for (k = 0; k < 8; k++) begin
            chk($sformatf("t1_wdata%0d", k), wd_q[k], exp_a[k]);
            chk1($sformatf("t1_wlast%0d", k), wl_q[k], (k % 4) == 3);
        end

        // Random READY stalls on AR/AW/W
        new_test();
        stall_en = 1;
        cnn_interrupt = 1'b1;
        tick();
        cnn_interrupt = 1'b0;
        wait_done(600, n);
        stall_en = 0;
        tick();
        chk("t2_aw0", aw_q[0], DST);
        chk("t2_aw1", aw_q[1], DST + 32'h10);
        chk("t2_wcount", 32'(wd_q.size()), 32'd8);
        for (k = 0; k < 8; k++) chk($sformatf("t2_wdata%0d", k), wd_q[k], exp_a[k]);
        chk1("t2_err", err, 1'b0);

        // Early RLAST on vector 0
        new_test();
        r_last0 = 1;
        cnn_interrupt = 1'b1;
        tick();
        cnn_interrupt = 1'b0;
        wait_done(200, n);
        r_last0 = 3;
        chk1("t3_err", err, 1'b1);
        tick();
        for (k = 0; k < 8; k++) chk($sformatf("t3_wdata%0d", k), wd_q[k], exp_s[k]);
        chk1("t3_wlast3", wl_q[3], 1'b1);

        // SLVERR on vector 0 write response
        new_test();
        bresp0 = 2'b10;
        cnn_interrupt = 1'b1;
        tick();
        chk1("t4_err_cleared_on_start", err, 1'b0);
        cnn_interrupt = 1'b0;
        wait_done(200, n);
        bresp0 = 2'b00;
        chk1("t4_err_at_done", err, 1'b1);
        tick();
        chk1("t4_err_sticky", err, 1'b1);
        chk("t4_aw_count", 32'(aw_q.size()), 32'd2);

        // Interrupt edge during vector 1 is queued and serviced after done
        new_test();
        cnn_interrupt = 1'b1;
        tick();
        chk1("t5_err_cleared", err, 1'b0);
        chk("t5_vec_idx0", 32'(vec_idx), 32'd0);
        cnn_interrupt = 1'b0;
        wait_vec1(100);
        cnn_interrupt = 1'b1;
        tick();
        cnn_interrupt = 1'b0;
        wait_done(200, n);
        chk1("t5_arvalid_at_done", ARVALID, 1'b0);
        chk1("t5_busy_at_done", busy, 1'b0);
        tick();
        chk1("t5_restart_arvalid", ARVALID, 1'b1);
        chk1("t5_restart_busy", busy, 1'b1);
        chk("t5_restart_vec_idx", 32'(vec_idx), 32'd0);
        wait_done(200, n);
        tick();
        chk("t5_aw_count", 32'(aw_q.size()), 32'd4);
        chk("t5_aw2", aw_q[2], DST);
        chk("t5_aw3", aw_q[3], DST + 32'h10);
        chk("t5_wdata8", wd_q[8], 32'h99);
        chk("t5_wdata15", wd_q[15], 32'h110);

        // Reset during W beat 2 of vector 0
        new_test();
        cnn_interrupt = 1'b1;
        tick();
        cnn_interrupt = 1'b0;
        n = 0;
        while (!(WVALID && w_cnt == 1) && n < 100) begin tick(); n++; end
        chk1("t6_reached_w_beat2", WVALID && (w_cnt == 1), 1'b1);
        #1;
        resetn = 1'b0;
        #1;
        chk1("t6_wvalid", WVALID, 1'b0);
        chk1("t6_busy", busy, 1'b0);
        chk("t6_vec_idx", 32'(vec_idx), 32'd0);
        chk("t6_wdata", WDATA, 32'd0);
        chk1("t6_bready", BREADY, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        new_test();
        tick();
        cnn_interrupt = 1'b1;
        tick();
        chk1("t6_restart_arvalid", ARVALID, 1'b1);
        cnn_interrupt = 1'b0;
        wait_done(200, n);
        chk("t6_latency", 32'(n + 1), 32'd23);
        tick();
        chk("t6_aw0", aw_q[0], DST);
        chk("t6_aw_count", 32'(aw_q.size()), 32'd2);
        chk("t6_wdata0", wd_q[0], 32'h11);
        chk("t6_wdata7", wd_q[7], 32'h88);
        chk1("t6_err", err, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
